// File: rtl/ifetch_buffer_if.sv
// Fetch-unit bus: redirect from decode, instruction-memory request/response,
// and the {pc, instr} head presented to decode.
interface ifetch_buffer_if;
  logic        redirect_i;
  logic [63:0] redirect_pc_i;
  logic        imem_req_valid_o;
  logic        imem_req_ready_i;
  logic [63:0] imem_req_addr_o;
  logic        imem_resp_valid_i;
  logic [31:0] imem_resp_instr_i;
  logic        f_valid_o;
  logic [63:0] f_pc_o;
  logic [31:0] f_instr_o;
  logic        f_ready_i;

  // Fetch unit side
  modport master (
    input  redirect_i, redirect_pc_i, imem_req_ready_i, imem_resp_valid_i,
           imem_resp_instr_i, f_ready_i,
    output imem_req_valid_o, imem_req_addr_o, f_valid_o, f_pc_o, f_instr_o
  );

  // Memory / decode side
  modport slave (
    output redirect_i, redirect_pc_i, imem_req_ready_i, imem_resp_valid_i,
           imem_resp_instr_i, f_ready_i,
    input  imem_req_valid_o, imem_req_addr_o, f_valid_o, f_pc_o, f_instr_o
  );
endinterface

// File: rtl/ifetch_buffer.sv
// Instruction fetch front-end: issues sequential fetch requests under a credit
// limit, buffers in-order responses in a small FIFO for decode, and flushes on
// redirect while discarding responses that were already in flight.
module ifetch_buffer #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input logic             clk_i,
  input logic             rst_i,
  ifetch_buffer_if.master fetch_io
);
  localparam int unsigned   PtrW   = $clog2(DEPTH);
  localparam int unsigned   CntW   = PtrW + 1;
  localparam logic [CntW:0] DepthW = DEPTH[CntW:0];

  logic [63:0]     r_fetch_pc;
  logic [63:0]     r_resp_pc;
  logic [CntW-1:0] r_in_flight;
  logic [CntW-1:0] r_drop_cnt;
  logic [CntW-1:0] r_count;
  logic [PtrW-1:0] r_rd_ptr;
  logic [PtrW-1:0] r_wr_ptr;
  logic [63:0]     r_buf_pc    [DEPTH];
  logic [31:0]     r_buf_instr [DEPTH];

  logic            w_req_valid;
  logic            w_req_fire;
  logic            w_resp;
  logic            w_drop;
  logic            w_push;
  logic            w_pop;
  logic            w_f_valid;
  logic [CntW:0]   w_used;

  // Credit check, handshakes and response classification
  always_comb begin
    // Buffered plus outstanding must stay below DEPTH so a push never finds the FIFO full
    w_used      = {1'b0, r_in_flight} + {1'b0, r_count};
    w_req_valid = !rst_i && !fetch_io.redirect_i && (w_used < DepthW);
    w_req_fire  = w_req_valid && fetch_io.imem_req_ready_i;
    w_resp      = fetch_io.imem_resp_valid_i;
    w_drop      = w_resp && (r_drop_cnt != '0);
    w_push      = w_resp && !w_drop;
    w_f_valid   = (r_count != '0);
    w_pop       = w_f_valid && fetch_io.f_ready_i;
  end

  assign fetch_io.imem_req_valid_o = w_req_valid;
  assign fetch_io.imem_req_addr_o  = r_fetch_pc;
  assign fetch_io.f_valid_o        = w_f_valid;
  assign fetch_io.f_pc_o           = w_f_valid ? r_buf_pc[r_rd_ptr] : 64'h0;
  assign fetch_io.f_instr_o        = w_f_valid ? r_buf_instr[r_rd_ptr] : 32'h0;

  // PCs, credit/drop counters and FIFO pointers; reset beats redirect beats normal flow
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_fetch_pc  <= RESET_PC;
      r_resp_pc   <= RESET_PC;
      r_in_flight <= '0;
      r_drop_cnt  <= '0;
      r_count     <= '0;
      r_rd_ptr    <= '0;
      r_wr_ptr    <= '0;
    end else if (fetch_io.redirect_i) begin
      r_fetch_pc  <= fetch_io.redirect_pc_i;
      r_resp_pc   <= fetch_io.redirect_pc_i;
      // Everything still outstanding is stale; a response this cycle is consumed now
      r_in_flight <= r_in_flight - CntW'(w_resp);
      r_drop_cnt  <= r_in_flight - CntW'(w_resp);
      r_count     <= '0;
      r_rd_ptr    <= '0;
      r_wr_ptr    <= '0;
    end else begin
      if (w_req_fire) begin
        r_fetch_pc <= r_fetch_pc + 64'd4;
      end
      r_in_flight <= r_in_flight + CntW'(w_req_fire) - CntW'(w_resp);
      if (w_drop) begin
        r_drop_cnt <= r_drop_cnt - CntW'(1);
      end
      if (w_push) begin
        r_resp_pc <= r_resp_pc + 64'd4;
        r_wr_ptr  <= r_wr_ptr + PtrW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PtrW'(1);
      end
      r_count <= r_count + CntW'(w_push) - CntW'(w_pop);
    end
  end

  // FIFO storage; contents need no reset because the head is gated by count
  always_ff @(posedge clk_i) begin
    if (!rst_i && !fetch_io.redirect_i && w_push) begin
      r_buf_pc[r_wr_ptr]    <= r_resp_pc;
      r_buf_instr[r_wr_ptr] <= fetch_io.imem_resp_instr_i;
    end
  end
endmodule

// File: tb/tb_ifetch_buffer.sv
// Bench for ifetch_buffer: in-order memory model with programmable latency,
// expected {pc, instr} scoreboard, cycle tables and hand-written corner cases.
module tb_ifetch_buffer;
  localparam int unsigned DEPTH    = 4;
  localparam logic [63:0] RESET_PC = 64'h0;

  typedef struct { logic [63:0] addr; int due; } mreq_t;
  typedef struct { logic [63:0] pc; logic [31:0] instr; } exp_t;
  typedef struct {
    logic        req_ready;
    logic        f_ready;
    logic        exp_rv;
    logic [63:0] exp_addr;
    logic        exp_fv;
    logic [63:0] exp_pc;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ifetch_buffer_if bus ();

  ifetch_buffer #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .fetch_io (bus)
  );

  mreq_t       mem_q[$];
  exp_t        exp_q[$];
  int          cyc = 0;
  int          lat = 1;
  int          checks = 0;
  int          errors = 0;
  logic        req_ready = 1'b1;
  logic        f_ready = 1'b1;
  logic        redirect = 1'b0;
  logic [63:0] redirect_pc = 64'h0;
  logic [63:0] exp_next = RESET_PC;
  logic        popped = 1'b0;
  vec_t        t1[8];
  vec_t        t2[13];

  function automatic logic [31:0] instr_of(logic [63:0] a);
    return a[31:0] ^ 32'hC3A5_1E0F;
  endfunction

  function automatic vec_t mk(logic rr, logic fr, logic rv, logic [63:0] a, logic fv,
                              logic [63:0] pc);
    vec_t v;
    v.req_ready = rr; v.f_ready = fr; v.exp_rv = rv; v.exp_addr = a;
    v.exp_fv = fv; v.exp_pc = pc;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Drive this cycle's inputs just after the falling edge, let them settle, then sample.
  task automatic tick_pre();
    exp_t e;
    bus.redirect_i        = redirect;
    bus.redirect_pc_i     = redirect_pc;
    bus.imem_req_ready_i  = req_ready;
    bus.f_ready_i         = f_ready;
    bus.imem_resp_valid_i = 1'b0;
    bus.imem_resp_instr_i = 32'h0;
    popped = 1'b0;
    if (!rst && mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      bus.imem_resp_valid_i = 1'b1;
      bus.imem_resp_instr_i = instr_of(mem_q[0].addr);
      void'(mem_q.pop_front());
    end
    #1;
    if (rst) begin
      mem_q.delete();
      exp_q.delete();
      exp_next = RESET_PC;
      check("rst_req_valid", 64'(bus.imem_req_valid_o), 64'h0);
    end else begin
      if (dut.w_push && !redirect) begin
        checks++;
        if (32'(dut.r_count) >= DEPTH) begin
          errors++;
          $display("FAIL fifo_overflow: push with count %0d, required below %0d",
                   dut.r_count, DEPTH);
        end
      end
      if (bus.f_valid_o && f_ready && !redirect) begin
        popped = 1'b1;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL pop_unexpected: got pc %h, expected no instruction", bus.f_pc_o);
        end else begin
          e = exp_q.pop_front();
          check("pop_pc", bus.f_pc_o, e.pc);
          check("pop_instr", 64'(bus.f_instr_o), 64'(e.instr));
        end
      end
      if (redirect) begin
        exp_q.delete();
        exp_next = redirect_pc;
      end
      if (bus.imem_req_valid_o && req_ready) begin
        check("req_addr", bus.imem_req_addr_o, exp_next);
        mem_q.push_back('{bus.imem_req_addr_o, cyc + lat});
        exp_q.push_back('{exp_next, instr_of(exp_next)});
        exp_next = exp_next + 64'd4;
      end
    end
  endtask

  task automatic tick_post();
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic tick();
    tick_pre();
    tick_post();
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) tick();
    rst = 1'b0;
  endtask

  // Runs until f_valid_o is seen (returned mid-cycle, after tick_pre) or the budget expires.
  task automatic wait_valid(input int start, input int max, output int k);
    k = start;
    while (k < max) begin
      k++;
      tick_pre();
      if (bus.f_valid_o) return;
      tick_post();
    end
  endtask

  task automatic run_table1();
    for (int i = 0; i < 8; i++) begin
      req_ready = t1[i].req_ready;
      f_ready   = t1[i].f_ready;
      tick_pre();
      check($sformatf("t1[%0d] req_valid", i), 64'(bus.imem_req_valid_o), 64'(t1[i].exp_rv));
      check($sformatf("t1[%0d] req_addr", i), bus.imem_req_addr_o, t1[i].exp_addr);
      check($sformatf("t1[%0d] f_valid", i), 64'(bus.f_valid_o), 64'(t1[i].exp_fv));
      check($sformatf("t1[%0d] f_pc", i), bus.f_pc_o, t1[i].exp_pc);
      tick_post();
    end
  endtask

  task automatic run_table2();
    for (int i = 0; i < 13; i++) begin
      req_ready = t2[i].req_ready;
      f_ready   = t2[i].f_ready;
      tick_pre();
      check($sformatf("t2[%0d] req_valid", i), 64'(bus.imem_req_valid_o), 64'(t2[i].exp_rv));
      check($sformatf("t2[%0d] req_addr", i), bus.imem_req_addr_o, t2[i].exp_addr);
      check($sformatf("t2[%0d] f_valid", i), 64'(bus.f_valid_o), 64'(t2[i].exp_fv));
      check($sformatf("t2[%0d] f_pc", i), bus.f_pc_o, t2[i].exp_pc);
      tick_post();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k;
    int n;
    bus.redirect_i = 1'b0; bus.redirect_pc_i = 64'h0; bus.imem_req_ready_i = 1'b0;
    bus.imem_resp_valid_i = 1'b0; bus.imem_resp_instr_i = 32'h0; bus.f_ready_i = 1'b0;

    // Free-run, L=1: head appears t+L+1 after the first accept, then no bubbles
    t1[0] = mk(1'b1, 1'b1, 1'b1, 64'h00, 1'b0, 64'h00);
    t1[1] = mk(1'b1, 1'b1, 1'b1, 64'h04, 1'b0, 64'h00);
    t1[2] = mk(1'b1, 1'b1, 1'b1, 64'h08, 1'b1, 64'h00);
    t1[3] = mk(1'b1, 1'b1, 1'b1, 64'h0C, 1'b1, 64'h04);
    t1[4] = mk(1'b1, 1'b1, 1'b1, 64'h10, 1'b1, 64'h08);
    t1[5] = mk(1'b1, 1'b1, 1'b1, 64'h14, 1'b1, 64'h0C);
    t1[6] = mk(1'b1, 1'b1, 1'b1, 64'h18, 1'b1, 64'h10);
    t1[7] = mk(1'b1, 1'b1, 1'b1, 64'h1C, 1'b1, 64'h14);
    // Backpressure, L=2: four accepts fill the credits, then drain in order
    t2[0]  = mk(1'b1, 1'b0, 1'b1, 64'h00, 1'b0, 64'h00);
    t2[1]  = mk(1'b1, 1'b0, 1'b1, 64'h04, 1'b0, 64'h00);
    t2[2]  = mk(1'b1, 1'b0, 1'b1, 64'h08, 1'b0, 64'h00);
    t2[3]  = mk(1'b1, 1'b0, 1'b1, 64'h0C, 1'b1, 64'h00);
    t2[4]  = mk(1'b1, 1'b0, 1'b0, 64'h10, 1'b1, 64'h00);
    t2[5]  = mk(1'b1, 1'b0, 1'b0, 64'h10, 1'b1, 64'h00);
    t2[6]  = mk(1'b1, 1'b0, 1'b0, 64'h10, 1'b1, 64'h00);
    t2[7]  = mk(1'b1, 1'b0, 1'b0, 64'h10, 1'b1, 64'h00);
    t2[8]  = mk(1'b1, 1'b1, 1'b0, 64'h10, 1'b1, 64'h00);
    t2[9]  = mk(1'b1, 1'b1, 1'b1, 64'h10, 1'b1, 64'h04);
    t2[10] = mk(1'b1, 1'b1, 1'b1, 64'h14, 1'b1, 64'h08);
    t2[11] = mk(1'b1, 1'b1, 1'b1, 64'h18, 1'b1, 64'h0C);
    t2[12] = mk(1'b1, 1'b1, 1'b1, 64'h1C, 1'b1, 64'h10);

    @(negedge clk);

    // Reset then free-run
    lat = 1; req_ready = 1'b1; f_ready = 1'b1;
    do_reset(2);
    run_table1();

    // Backpressure
    lat = 2; f_ready = 1'b0;
    do_reset(1);
    run_table2();

    // Redirect with two requests in flight, no response in the redirect cycle
    lat = 3; f_ready = 1'b1; req_ready = 1'b1;
    do_reset(1);
    tick(); tick();
    req_ready = 1'b0; tick(); tick();
    req_ready = 1'b1; tick(); tick();
    redirect = 1'b1; redirect_pc = 64'h100;
    tick_pre();
    check("t3 redirect req_valid", 64'(bus.imem_req_valid_o), 64'h0);
    tick_post();
    redirect = 1'b0;
    wait_valid(0, 20, k);
    check("t3 first valid offset", 64'(k), 64'd5);
    check("t3 first pc", bus.f_pc_o, 64'h100);
    check("t3 first instr", 64'(bus.f_instr_o), 64'(instr_of(64'h100)));
    tick_post();
    repeat (4) tick();

    // Redirect together with response, accept-ready and pop
    lat = 1; f_ready = 1'b1; req_ready = 1'b1;
    do_reset(1);
    repeat (6) tick();
    redirect = 1'b1; redirect_pc = 64'h200;
    tick_pre();
    check("t4 resp present", 64'(bus.imem_resp_valid_i), 64'h1);
    check("t4 redirect req_valid", 64'(bus.imem_req_valid_o), 64'h0);
    tick_post();
    redirect = 1'b0;
    tick_pre();
    check("t4 addr after redirect", bus.imem_req_addr_o, 64'h200);
    check("t4 req_valid after redirect", 64'(bus.imem_req_valid_o), 64'h1);
    check("t4 f_valid after redirect", 64'(bus.f_valid_o), 64'h0);
    tick_post();
    wait_valid(1, 20, k);
    check("t4 first valid offset", 64'(k), 64'd3);
    check("t4 first pc", bus.f_pc_o, 64'h200);
    tick_post();
    repeat (3) tick();

    // Memory stall at 0x40
    do_reset(1);
    n = 0;
    while (bus.imem_req_addr_o != 64'h40 && n < 40) begin
      tick();
      n++;
    end
    check("t5 reached 0x40", bus.imem_req_addr_o, 64'h40);
    req_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick_pre();
      check($sformatf("t5 stall[%0d] addr", i), bus.imem_req_addr_o, 64'h40);
      check($sformatf("t5 stall[%0d] req_valid", i), 64'(bus.imem_req_valid_o), 64'h1);
      tick_post();
    end
    req_ready = 1'b1;
    tick_pre();
    check("t5 resume addr", bus.imem_req_addr_o, 64'h40);
    tick_post();
    tick_pre();
    check("t5 next addr", bus.imem_req_addr_o, 64'h44);
    tick_post();
    repeat (6) tick();

    // Reset with a full FIFO
    lat = 1; f_ready = 1'b0;
    do_reset(1);
    repeat (10) tick();
    tick_pre();
    check("t6 full f_valid", 64'(bus.f_valid_o), 64'h1);
    check("t6 full req_valid", 64'(bus.imem_req_valid_o), 64'h0);
    tick_post();
    do_reset(1);
    f_ready = 1'b1;
    tick_pre();
    check("t6 post-reset f_valid", 64'(bus.f_valid_o), 64'h0);
    check("t6 post-reset f_pc", bus.f_pc_o, 64'h0);
    check("t6 post-reset f_instr", 64'(bus.f_instr_o), 64'h0);
    check("t6 post-reset addr", bus.imem_req_addr_o, RESET_PC);
    check("t6 post-reset req_valid", 64'(bus.imem_req_valid_o), 64'h1);
    tick_post();
    wait_valid(1, 20, k);
    check("t6 refetch pc", bus.f_pc_o, RESET_PC);
    tick_post();

    // Reset while two stale responses are pending
    lat = 3; f_ready = 1'b1; req_ready = 1'b1;
    do_reset(1);
    tick(); tick();
    redirect = 1'b1; redirect_pc = 64'h300;
    tick();
    redirect = 1'b0;
    do_reset(1);
    wait_valid(0, 20, k);
    check("t6b refetch pc", bus.f_pc_o, RESET_PC);
    check("t6b refetch offset", 64'(k), 64'd5);
    tick_post();
    repeat (4) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
